// File: rtl/qracc_pkg.sv
// Shared types and constants for the qracc feature path (fetcher/loader).
// Holds only declarations: no logic, no latency, no flow control.
package qracc_pkg;

    localparam int FF_INPUT_WIDTH   = 256;
    localparam int FF_ELEMENT_WIDTH = 8;
    localparam int FF_NUM_ELEMENTS  = 128;
    localparam int FF_WPB           = FF_INPUT_WIDTH / FF_ELEMENT_WIDTH;

    typedef enum logic [1:0] {
        FF_IDLE,
        FF_FETCH,
        FF_DRAIN,
        FF_DONE
    } ff_state_t;

    typedef struct packed {
        logic [31:0] stat_ff_beats;
    } ff_stats_t;

endpackage

// File: rtl/feature_fetcher.sv
// Streams an activation vector from SRAM into the feature_loader, one word per grant; write lands 2 cycles after grant.
// Grant low stalls issue indefinitely; done_o pulses the cycle after the last loader write.
module feature_fetcher
    import qracc_pkg::*;
#(
    parameter int inputWidth       = FF_INPUT_WIDTH,
    parameter int addrWidth        = 8,
    parameter int elementWidth     = FF_ELEMENT_WIDTH,
    parameter int numElements      = FF_NUM_ELEMENTS,
    parameter int sramAddrWidth    = 16,
    parameter bit TRACK_STATISTICS = 1'b1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start_i,
    input  logic [sramAddrWidth-1:0] base_addr_i,
    input  logic [9:0]               num_elems_i,
    input  logic [9:0]               mask_start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     sram_req_o,
    input  logic                     sram_gnt_i,
    output logic [sramAddrWidth-1:0] sram_addr_o,
    input  logic [inputWidth-1:0]    sram_rdata_i,
    output logic                     fl_wr_en_o,
    output logic [addrWidth-1:0]     fl_addr_o,
    output logic [inputWidth-1:0]    fl_data_o,
    output logic [9:0]               fl_mask_start_o,
    output logic [9:0]               fl_mask_end_o
);

    localparam int WPB       = inputWidth / elementWidth;
    localparam int WPB_LOG   = $clog2(WPB);
    localparam int MAX_BEATS = (numElements + WPB - 1) / WPB;
    localparam int BW        = $clog2(MAX_BEATS + 1);

    ff_state_t                state, state_nxt;
    logic [9:0]               n_lat;
    logic [9:0]               n_clamp;
    logic [9:0]               n_round;
    logic [9:0]               rem;
    logic [BW-1:0]            beats;
    logic [BW-1:0]            beats_calc;
    logic [BW-1:0]            issued;
    logic [BW-1:0]            returned;
    logic [sramAddrWidth-1:0] base;
    logic                     issue;
    logic                     rd_pend;
    logic                     accept;
    logic [inputWidth-1:0]    tail_data;

    assign n_clamp    = (num_elems_i > 10'(numElements)) ? 10'(numElements) : num_elems_i;
    assign n_round    = n_clamp + 10'(WPB - 1);
    assign beats_calc = BW'(n_round >> WPB_LOG);

    assign accept      = (state == FF_IDLE) && start_i;
    assign issue       = (state == FF_FETCH) && sram_gnt_i;
    assign sram_req_o  = (state == FF_FETCH);
    assign sram_addr_o = base + sramAddrWidth'(issued);
    assign busy_o      = (state != FF_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            FF_IDLE: begin
                if (start_i) begin
                    state_nxt = (n_clamp == '0) ? FF_DONE : FF_FETCH;
                end
            end
            FF_FETCH: begin
                if (issue && (issued + BW'(1) == beats)) begin
                    state_nxt = FF_DRAIN;
                end
            end
            // Leave once the final word is on the read bus; its write lands during DONE.
            FF_DRAIN: begin
                if (returned + BW'(rd_pend) == beats) begin
                    state_nxt = FF_DONE;
                end
            end
            FF_DONE:  state_nxt = FF_IDLE;
            default:  state_nxt = FF_IDLE;
        endcase
    end

    // Lanes past the vector end on the final beat are zeroed.
    always_comb begin
        rem       = n_lat - (10'(returned) << WPB_LOG);
        tail_data = '0;
        for (int i = 0; i < WPB; i++) begin
            if (10'(i) < rem) begin
                tail_data[(WPB-1-i)*elementWidth +: elementWidth] =
                    sram_rdata_i[(WPB-1-i)*elementWidth +: elementWidth];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= FF_IDLE;
            n_lat           <= '0;
            beats           <= '0;
            base            <= '0;
            issued          <= '0;
            returned        <= '0;
            rd_pend         <= 1'b0;
            done_o          <= 1'b0;
            fl_wr_en_o      <= 1'b0;
            fl_addr_o       <= '0;
            fl_data_o       <= '0;
            fl_mask_start_o <= '0;
            fl_mask_end_o   <= '0;
        end else begin
            state      <= state_nxt;
            rd_pend    <= issue;
            fl_wr_en_o <= rd_pend;
            done_o     <= (state == FF_DONE);
            if (accept) begin
                n_lat           <= n_clamp;
                beats           <= beats_calc;
                base            <= base_addr_i;
                issued          <= '0;
                returned        <= '0;
                fl_mask_start_o <= mask_start_i;
                fl_mask_end_o   <= n_clamp;
            end
            if (issue) begin
                issued <= issued + BW'(1);
            end
            if (rd_pend) begin
                fl_data_o <= tail_data;
                fl_addr_o <= addrWidth'(32'(returned) << WPB_LOG);
                returned  <= returned + BW'(1);
            end
        end
    end

    if (TRACK_STATISTICS) begin : g_stats
        ff_stats_t stats;
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                stats <= '0;
            end else if (issue) begin
                stats.stat_ff_beats <= stats.stat_ff_beats + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_feature_fetcher.sv
// Directed bench for feature_fetcher: a vector table of whole operations plus reset-abort and idle checks.
module tb_feature_fetcher;
    import qracc_pkg::*;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start_i;
    logic [15:0]  base_addr_i;
    logic [9:0]   num_elems_i;
    logic [9:0]   mask_start_i;
    logic         busy_o;
    logic         done_o;
    logic         sram_req_o;
    logic         sram_gnt_i;
    logic [15:0]  sram_addr_o;
    logic [255:0] sram_rdata_i;
    logic         fl_wr_en_o;
    logic [7:0]   fl_addr_o;
    logic [255:0] fl_data_o;
    logic [9:0]   fl_mask_start_o;
    logic [9:0]   fl_mask_end_o;

    int total  = 0;
    int passed = 0;

    localparam logic [255:0] JUNK = {64{4'hA}};

    feature_fetcher dut (
        .clk             (clk),
        .nrst            (nrst),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .num_elems_i     (num_elems_i),
        .mask_start_i    (mask_start_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .sram_req_o      (sram_req_o),
        .sram_gnt_i      (sram_gnt_i),
        .sram_addr_o     (sram_addr_o),
        .sram_rdata_i    (sram_rdata_i),
        .fl_wr_en_o      (fl_wr_en_o),
        .fl_addr_o       (fl_addr_o),
        .fl_data_o       (fl_data_o),
        .fl_mask_start_o (fl_mask_start_o),
        .fl_mask_end_o   (fl_mask_end_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [15:0] base;
        logic [9:0] mstart;
        logic [3:0] gpat;        // bit k = grant in FETCH cycle k+1 (repeats every 4)
        int         extra_start; // cycle of a second start pulse, 0 = none
        int         exp_beats;
        int         exp_mend;
        int         exp_done;    // cycle of done_o, start driven in cycle 0
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every lane has bit 7 set so zeroed lanes are always distinguishable.
    function automatic logic [255:0] word_of(input logic [15:0] a);
        logic [255:0] w;
        logic [4:0]   li;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            li = 5'(i);
            w[(31-i)*8 +: 8] = {1'b1, a[1:0], li};
        end
        return w;
    endfunction

    function automatic logic [255:0] exp_beat(input logic [15:0] a, input int nc, input int k);
        logic [255:0] w;
        int           r;
        w = word_of(a);
        r = nc - k * 32;
        for (int i = 0; i < 32; i++) begin
            if (i >= r) w[(31-i)*8 +: 8] = 8'h00;
        end
        return w;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int           done_cyc;
        int           nrd;
        int           nwr;
        int           nc;
        logic         pend;
        logic [15:0]  paddr;
        string        tag;
        tag          = $sformatf("v%0d", idx);
        nc           = (v.n > 128) ? 128 : v.n;
        done_cyc     = -1;
        nrd          = 0;
        nwr          = 0;
        pend         = 1'b0;
        paddr        = '0;
        start_i      = 1'b1;
        num_elems_i  = 10'(v.n);
        base_addr_i  = v.base;
        mask_start_i = v.mstart;
        sram_gnt_i   = 1'b0;
        sram_rdata_i = JUNK;
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            if (cyc > 0) begin
                start_i = (cyc == v.extra_start);
                if (cyc == v.extra_start) begin
                    num_elems_i  = 10'd10;
                    base_addr_i  = 16'h0300;
                    mask_start_i = 10'd9;
                end
                sram_gnt_i   = v.gpat[(cyc - 1) % 4];
                sram_rdata_i = pend ? word_of(paddr) : JUNK;
            end
            #1;
            pend = sram_req_o && sram_gnt_i;
            if (pend) begin
                chk({tag, "_rd_addr"}, 256'(sram_addr_o), 256'(v.base + 16'(nrd)));
                paddr = sram_addr_o;
                nrd++;
            end
            if (fl_wr_en_o) begin
                chk({tag, "_wr_addr"}, 256'(fl_addr_o), 256'(8'(nwr * 32)));
                chk({tag, "_wr_data"}, fl_data_o, exp_beat(v.base + 16'(nwr), nc, nwr));
                nwr++;
            end
            if (done_o) begin
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, 256'(busy_o), 256'(0));
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        chk({tag, "_done_cycle"}, 256'(done_cyc), 256'(v.exp_done));
        chk({tag, "_reads"}, 256'(nrd), 256'(v.exp_beats));
        chk({tag, "_writes"}, 256'(nwr), 256'(v.exp_beats));
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_mask_start"}, 256'(fl_mask_start_o), 256'(v.mstart));
        chk({tag, "_mask_end"}, 256'(fl_mask_end_o), 256'(v.exp_mend));
        chk({tag, "_idle"}, 256'({busy_o, done_o, sram_req_o}), 256'(0));
    endtask

    task automatic reset_in_drain();
        int   done_seen;
        logic pend;
        logic [15:0] paddr;
        pend         = 1'b0;
        paddr        = '0;
        done_seen    = 0;
        start_i      = 1'b1;
        num_elems_i  = 10'd128;
        base_addr_i  = 16'h0040;
        mask_start_i = 10'd4;
        sram_gnt_i   = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc > 0) start_i = 1'b0;
            sram_rdata_i = pend ? word_of(paddr) : JUNK;
            #1;
            pend  = sram_req_o && sram_gnt_i;
            paddr = sram_addr_o;
            @(negedge clk);
        end
        // Cycle 5: all four reads granted, fetcher is draining.
        #1;
        chk("rst_pre_busy", 256'(busy_o), 256'(1));
        nrst = 1'b0;
        #1;
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_wr_en", 256'(fl_wr_en_o), 256'(0));
        chk("rst_data", fl_data_o, 256'(0));
        chk("rst_mask", 256'({fl_mask_start_o, fl_mask_end_o}), 256'(0));
        @(negedge clk);
        nrst       = 1'b1;
        sram_gnt_i = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            if (done_o || fl_wr_en_o || sram_req_o) done_seen++;
        end
        chk("rst_no_done", 256'(done_seen), 256'(0));
    endtask

    initial begin
        vecs[0] = '{128, 16'h0040, 10'd0, 4'b1111, 0, 4, 128, 7};
        vecs[1] = '{40,  16'h0100, 10'd3, 4'b1111, 0, 2, 40,  5};
        vecs[2] = '{0,   16'h0010, 10'd7, 4'b1111, 0, 0, 0,   2};
        vecs[3] = '{300, 16'h0200, 10'd1, 4'b0101, 0, 4, 128, 10};
        vecs[4] = '{64,  16'h0000, 10'd5, 4'b1111, 0, 2, 64,  5};
        vecs[5] = '{33,  16'h0020, 10'd2, 4'b1100, 0, 2, 33,  7};
        vecs[6] = '{1,   16'hFFFF, 10'd0, 4'b1111, 0, 1, 1,   4};
        vecs[7] = '{32,  16'h0007, 10'd9, 4'b1111, 0, 1, 32,  4};
        vecs[8] = '{128, 16'h0040, 10'd0, 4'b1111, 2, 4, 128, 7};

        nrst         = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        num_elems_i  = '0;
        mask_start_i = '0;
        sram_gnt_i   = 1'b0;
        sram_rdata_i = JUNK;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", 256'({busy_o, done_o, sram_req_o, fl_wr_en_o}), 256'(0));
        chk("reset_addr", 256'({sram_addr_o, fl_addr_o}), 256'(0));
        chk("reset_data", fl_data_o, 256'(0));
        chk("reset_mask", 256'({fl_mask_start_o, fl_mask_end_o}), 256'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        reset_in_drain();
        @(negedge clk);
        run_vec(vecs[1], 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
